// File: rtl/uart_byte_rx.sv
// UART byte receiver: 2-FF synchronized line, 16x oversampling, 3-sample majority vote.
// Define PARITY_CHECK_EN for 8E1 frames with parity checking; default build is 8N1.
module uart_byte_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [2:0] Baud_set,
  input  logic       Uart_rx,
  output logic [7:0] Data_byte,
  output logic       Rx_done,
  output logic       Frame_err,
  output logic       Parity_err,
  output logic       Uart_state
);

  localparam logic [15:0] DIV_9600   = 16'(CLK_FREQ / (9600   * OVERSAMPLE) - 1);
  localparam logic [15:0] DIV_19200  = 16'(CLK_FREQ / (19200  * OVERSAMPLE) - 1);
  localparam logic [15:0] DIV_38400  = 16'(CLK_FREQ / (38400  * OVERSAMPLE) - 1);
  localparam logic [15:0] DIV_57600  = 16'(CLK_FREQ / (57600  * OVERSAMPLE) - 1);
  localparam logic [15:0] DIV_115200 = 16'(CLK_FREQ / (115200 * OVERSAMPLE) - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PARITY_CHECK_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t      state;
  logic        rx_s1;
  logic        rx_s2;
  logic        rx_prev;
  logic [2:0]  baud_lat;
  logic [15:0] div;
  logic [15:0] div_cnt;
  logic [3:0]  tick_cnt;
  logic [2:0]  bit_cnt;
  logic [1:0]  samp;
  logic [7:0]  shift;
`ifdef PARITY_CHECK_EN
  logic        par_bit;
`endif
  logic        fall;
  logic        tick;
  logic        vote;

  assign fall = rx_prev & ~rx_s2;
  assign tick = (div_cnt == div);
  // Third sample is the live synchronized line in the tick-9 cycle.
  assign vote = (samp[0] & samp[1]) | (samp[0] & rx_s2) | (samp[1] & rx_s2);

  always_comb begin
    // NOTE: the default arm assigns div on every path, so no latch is inferred.
    case (baud_lat)
      3'd1:    div = DIV_19200;
      3'd2:    div = DIV_38400;
      3'd3:    div = DIV_57600;
      3'd4:    div = DIV_115200;
      default: div = DIV_9600;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, whatever order the statements are written in.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      baud_lat   <= '0;
      div_cnt    <= '0;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      samp       <= '0;
      shift      <= '0;
`ifdef PARITY_CHECK_EN
      par_bit    <= 1'b0;
`endif
      Data_byte  <= '0;
      Rx_done    <= 1'b0;
      Frame_err  <= 1'b0;
      Parity_err <= 1'b0;
      Uart_state <= 1'b0;
    end else begin
      rx_s1      <= Uart_rx;
      rx_s2      <= rx_s1;
      rx_prev    <= rx_s2;
      Rx_done    <= 1'b0;
      Frame_err  <= 1'b0;
      Parity_err <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt  <= '0;
          tick_cnt <= '0;
          bit_cnt  <= '0;
          if (fall) begin
            state      <= START;
            baud_lat   <= Baud_set;
            Uart_state <= 1'b1;
          end
        end
        default: begin
          div_cnt <= tick ? '0 : div_cnt + 16'd1;
          if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == 4'd7) samp[0] <= rx_s2;
            if (tick_cnt == 4'd8) samp[1] <= rx_s2;
            case (state)
              START: begin
                if (tick_cnt == 4'd9 && vote) begin
                  state      <= IDLE;
                  Uart_state <= 1'b0;
                end else if (tick_cnt == 4'd15) begin
                  state <= DATA;
                end
              end
              DATA: begin
                if (tick_cnt == 4'd9) begin
                  shift <= {vote, shift[7:1]};
                end else if (tick_cnt == 4'd15) begin
                  bit_cnt <= bit_cnt + 3'd1;
`ifdef PARITY_CHECK_EN
                  if (bit_cnt == 3'd7) state <= PARITY;
`else
                  if (bit_cnt == 3'd7) state <= STOP;
`endif
                end
              end
`ifdef PARITY_CHECK_EN
              PARITY: begin
                if (tick_cnt == 4'd9)       par_bit <= vote;
                else if (tick_cnt == 4'd15) state   <= STOP;
              end
`endif
              STOP: begin
                // Leave at mid-stop so a back-to-back start edge is not missed.
                if (tick_cnt == 4'd9) begin
                  state      <= IDLE;
                  Uart_state <= 1'b0;
                  if (!vote) begin
                    Frame_err <= 1'b1;
`ifdef PARITY_CHECK_EN
                  end else if (^{shift, par_bit}) begin
                    Parity_err <= 1'b1;
`endif
                  end else begin
                    Data_byte <= shift;
                    Rx_done   <= 1'b1;
                  end
                end
              end
              default: begin
                state      <= IDLE;
                Uart_state <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
